// File: rtl/dmem_io_pkg.sv
// Shared constants for the dmem/MMIO bridge: register offsets and STATUS bits.
// The cycle counter is built only with DMEM_IO_CYCLE_COUNTER_EN defined.
package dmem_io_pkg;

    localparam int OFF_OUT_DATA = 0;
    localparam int OFF_STATUS   = 1;
    localparam int OFF_CYCLE    = 2;
    localparam int OFF_SCRATCH  = 3;

    localparam int ST_EMPTY    = 0;
    localparam int ST_FULL     = 1;
    localparam int ST_OVF      = 2;
    localparam int ST_COUNT_LO = 3;
    localparam int ST_COUNT_W  = 3;

endpackage

// File: rtl/dmem_io_fifo.sv
// Output FIFO for the MMIO block: synchronous push/pop, head read combinationally.
// Pointers are log2(DEPTH) bits so they wrap naturally for power-of-two depths.
module dmem_io_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    always_ff @(posedge clock) begin
        if (push) mem[wptr] <= wdata;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/dmem_io_bridge.sv
// Data-memory responder: RAM passthrough below IO_BASE, MMIO block above it.
// Define DMEM_IO_CYCLE_COUNTER_EN to build the CYCLE register at offset +2.
module dmem_io_bridge
    import dmem_io_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] IO_BASE = 'hF00
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data,
    input  logic              wren,
    output logic [DATA_W-1:0] q,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic              is_io;
    logic [ADDR_W-1:0] off;
    logic              io_wr;
    logic              wr_out;
    logic              wr_st;
    logic              wr_scr;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [CW-1:0]     count;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] status;
    logic [DATA_W-1:0] rd_mux;
    logic              sel_io_q;
    logic [DATA_W-1:0] io_rdata_q;
    logic              ovf;
    logic [DATA_W-1:0] scratch;
    logic [31:0]       cycle;

    assign is_io = (address >= IO_BASE);
    assign off   = address - IO_BASE;

    assign ram_address = address;
    assign ram_data    = data;
    assign ram_wren    = wren & ~is_io & reset;

    assign io_wr  = wren & is_io;
    assign wr_out = io_wr & (off == ADDR_W'(OFF_OUT_DATA));
    assign wr_st  = io_wr & (off == ADDR_W'(OFF_STATUS));
    assign wr_scr = io_wr & (off == ADDR_W'(OFF_SCRATCH));

    // A push into a full FIFO still lands if the head leaves this cycle.
    assign pop  = out_valid & out_ready;
    assign push = wr_out & (~full | pop);

    dmem_io_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (DATA_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (data),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign out_valid = ~empty;
    assign out_data  = empty ? '0 : head;

    always_comb begin
        status = '0;
        status[ST_EMPTY] = empty;
        status[ST_FULL]  = full;
        status[ST_OVF]   = ovf;
        status[ST_COUNT_LO +: ST_COUNT_W] = ST_COUNT_W'(count);
    end

    always_comb begin
        rd_mux = '0;
        if (is_io) begin
            case (off)
                ADDR_W'(OFF_STATUS):  rd_mux = status;
                ADDR_W'(OFF_CYCLE):   rd_mux = DATA_W'(cycle);
                ADDR_W'(OFF_SCRATCH): rd_mux = scratch;
                default:              rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sel_io_q   <= 1'b0;
            io_rdata_q <= '0;
            ovf        <= 1'b0;
            scratch    <= '0;
        end else begin
            sel_io_q   <= is_io;
            io_rdata_q <= rd_mux;
            if (wr_out & full & ~pop)
                ovf <= 1'b1;
            else if (wr_st & data[ST_OVF])
                ovf <= 1'b0;
            if (wr_scr) scratch <= data;
        end
    end

`ifdef DMEM_IO_CYCLE_COUNTER_EN
    logic wr_cyc;
    assign wr_cyc = io_wr & (off == ADDR_W'(OFF_CYCLE));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            cycle <= '0;
        else if (wr_cyc)
            cycle <= 32'(data);
        else
            cycle <= cycle + 32'd1;
    end
`else
    assign cycle = '0;
`endif

    assign q = !reset ? '0 : (sel_io_q ? io_rdata_q : ram_q);

endmodule

// File: tb/tb_dmem_io_bridge.sv
// Scoreboard bench for dmem_io_bridge: stimulus queues expected q and FIFO
// output words, a negedge monitor pops and compares them as the DUT presents them.
module tb_dmem_io_bridge;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] address = '0;
    logic [31:0] data = '0;
    logic        wren = 1'b0;
    logic [31:0] q;
    logic [11:0] ram_address;
    logic [31:0] ram_data;
    logic        ram_wren;
    logic [31:0] ram_q = '0;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] q_exp[$];
    logic [31:0] f_exp[$];
    logic        chk = 1'b0;
    logic        pend = 1'b0;
    logic [31:0] ram_mem [0:4095];

    dmem_io_bridge dut (
        .clock       (clock),
        .reset       (reset),
        .address     (address),
        .data        (data),
        .wren        (wren),
        .q           (q),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_wren    (ram_wren),
        .ram_q       (ram_q),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ram_wren) ram_mem[ram_address] <= ram_data;
        ram_q <= ram_mem[ram_address];
    end

    task automatic cmp(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (pend && reset) begin
            if (q_exp.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL q_scoreboard: got read with no expected value");
            end else begin
                cmp("q", q, q_exp.pop_front());
            end
        end
        pend = chk && reset;
        if (reset && out_valid && out_ready) begin
            if (f_exp.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL fifo_scoreboard: got pop of %h with none expected",
                         out_data);
            end else begin
                cmp("out_data", out_data, f_exp.pop_front());
            end
        end
    end

    task automatic acc(input logic [11:0] a, input logic [31:0] d,
                       input logic w, input logic r, input logic c,
                       input logic [31:0] e);
        @(posedge clock);
        #1;
        address   = a;
        data      = d;
        wren      = w;
        out_ready = r;
        chk       = c;
        if (c) q_exp.push_back(e);
    endtask

    task automatic idle(input logic r, input int n);
        for (int i = 0; i < n; i++) acc(12'h000, 32'h0, 1'b0, r, 1'b0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] cyc_next;
        address = 12'h010;
        wren    = 1'b1;
        #12;
        cmp("rst_q", q, 32'h0);
        cmp("rst_out_valid", 32'(out_valid), 32'h0);
        cmp("rst_out_data", out_data, 32'h0);
        cmp("rst_ram_wren", 32'(ram_wren), 32'h0);
        wren = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;

        acc(12'h010, 32'h1234, 1'b1, 1'b0, 1'b0, 32'h0);
        #1 cmp("ram_wren_write", 32'(ram_wren), 32'h1);
        acc(12'h010, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1234);
        #1 cmp("ram_wren_read", 32'(ram_wren), 32'h0);
        acc(12'hF01, 32'h0, 1'b0, 1'b0, 1'b1, 32'h01);

        acc(12'hF00, 32'hA, 1'b1, 1'b0, 1'b0, 32'h0);
        acc(12'hF00, 32'hB, 1'b1, 1'b0, 1'b0, 32'h0);
        acc(12'hF00, 32'hC, 1'b1, 1'b0, 1'b0, 32'h0);
        acc(12'hF00, 32'hD, 1'b1, 1'b0, 1'b0, 32'h0);
        acc(12'hF00, 32'hE, 1'b1, 1'b0, 1'b0, 32'h0);
        f_exp.push_back(32'hA);
        f_exp.push_back(32'hB);
        f_exp.push_back(32'hC);
        f_exp.push_back(32'hD);
        acc(12'hF01, 32'h0, 1'b0, 1'b0, 1'b1, 32'h26);
        #1;
        cmp("full_out_valid", 32'(out_valid), 32'h1);
        cmp("full_head", out_data, 32'hA);
        idle(1'b1, 5);
        #1;
        cmp("drain1_out_valid", 32'(out_valid), 32'h0);
        cmp("drain1_left", 32'(f_exp.size()), 32'h0);

        acc(12'hF01, 32'h4, 1'b1, 1'b0, 1'b0, 32'h0);
        acc(12'hF01, 32'h0, 1'b0, 1'b0, 1'b1, 32'h01);

        for (int v = 1; v <= 4; v++) begin
            acc(12'hF00, 32'(v), 1'b1, 1'b0, 1'b0, 32'h0);
            f_exp.push_back(32'(v));
        end
        acc(12'hF00, 32'hF, 1'b1, 1'b1, 1'b0, 32'h0);
        f_exp.push_back(32'hF);
        acc(12'hF01, 32'h0, 1'b0, 1'b1, 1'b1, 32'h22);
        idle(1'b1, 5);
        #1;
        cmp("drain2_out_valid", 32'(out_valid), 32'h0);
        cmp("drain2_left", 32'(f_exp.size()), 32'h0);

`ifdef DMEM_IO_CYCLE_COUNTER_EN
        cyc_next = 32'h1;
`else
        cyc_next = 32'h0;
`endif
        acc(12'hF02, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 32'h0);
        idle(1'b0, 2);
        acc(12'hF02, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
        acc(12'hF02, 32'h0, 1'b0, 1'b0, 1'b1, cyc_next);

        acc(12'hF03, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 32'h0);
        acc(12'hF03, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        acc(12'hF07, 32'h1111, 1'b1, 1'b0, 1'b0, 32'h0);
        acc(12'hF07, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);

        acc(12'hF03, 32'h55, 1'b1, 1'b0, 1'b0, 32'h0);
        acc(12'hF00, 32'h7, 1'b1, 1'b0, 1'b0, 32'h0);
        acc(12'hF00, 32'h8, 1'b1, 1'b0, 1'b0, 32'h0);
        acc(12'hF00, 32'h9, 1'b1, 1'b0, 1'b0, 32'h0);
        acc(12'hF01, 32'h0, 1'b0, 1'b0, 1'b1, 32'h18);
        acc(12'hF03, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clock);
        #2;
        cmp("pre_rst_q", q, 32'h55);
        cmp("pre_rst_out_valid", 32'(out_valid), 32'h1);
        #1 reset = 1'b0;
        #1;
        cmp("mid_rst_q", q, 32'h0);
        cmp("mid_rst_out_valid", 32'(out_valid), 32'h0);
        cmp("mid_rst_out_data", out_data, 32'h0);
        @(posedge clock);
        #1 reset = 1'b1;
        acc(12'hF01, 32'h0, 1'b0, 1'b0, 1'b1, 32'h01);
        acc(12'hF03, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
        idle(1'b0, 2);
        #1 cmp("q_left", 32'(q_exp.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
